// File: rtl/acq_pkg.sv
// Shared types and widths for the acquisition sequencer slice.
package acq_pkg;

  localparam int ACQ_DATA_W = 47;
  localparam int ACQ_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } acq_state_t;

endpackage

// File: rtl/acq_sequencer_if.sv
// Tagger-to-FIFO record path between the sequencer (master) and its environment (slave).
interface acq_sequencer_if
  import acq_pkg::*;
#(
  parameter int DATA_W = ACQ_DATA_W
) ();

  logic              tagger_rdy;
  logic [DATA_W-1:0] tagger_data;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_wdata;

  modport master (
    input  tagger_rdy,
    input  tagger_data,
    input  fifo_full,
    output fifo_wr,
    output fifo_wdata
  );

  modport slave (
    output tagger_rdy,
    output tagger_data,
    output fifo_full,
    input  fifo_wr,
    input  fifo_wdata
  );

endinterface

// File: rtl/acq_run_timer.sv
// Run-length timer: latches the duration on load and flags the final RUN cycle.
module acq_run_timer
  import acq_pkg::*;
#(
  parameter int CNT_W = ACQ_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] duration,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] dur_q;
  logic [CNT_W-1:0] timer_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dur_q   <= '0;
      timer_q <= '0;
    end else if (load) begin
      dur_q   <= duration;
      timer_q <= '0;
    end else if (en) begin
      timer_q <= timer_q + ONE;
    end
  end

  // A zero duration never terminates; the run then ends only on a stop command.
  assign done = en && (dur_q != '0) && ((timer_q + ONE) == dur_q);

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition run sequencer: IDLE -> ARM -> RUN -> DRAIN, forwarding tagger records to a FIFO.
// Define ACQ_SEQ_LOST_CNT_EN to count records dropped on a full FIFO; otherwise lost_count is 0.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int DATA_W       = ACQ_DATA_W,
  parameter int RESET_CYCLES = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_start,
  input  logic                 cmd_stop,
  input  logic [ACQ_CNT_W-1:0] duration,
  acq_sequencer_if.master      io,
  output logic                 operate,
  output logic                 reset_counter,
  output logic                 busy,
  output logic [1:0]           state,
  output logic [ACQ_CNT_W-1:0] record_count,
  output logic [15:0]          lost_count
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ARM   = ARM;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  localparam logic [3:0] ARM_LAST   = 4'(RESET_CYCLES - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           phase_q, phase_d;
  logic                 busy_q, operate_q, rst_cnt_q;
  logic                 fifo_wr_q;
  logic [DATA_W-1:0]    fifo_wdata_q;
  logic [ACQ_CNT_W-1:0] record_q;
  logic                 start_run;
  logic                 timer_done;
  logic                 accept;

  acq_run_timer #(.CNT_W(ACQ_CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start_run),
    .en       (state_q == ST_RUN),
    .duration (duration),
    .done     (timer_done)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    start_run = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d   = ST_ARM;
          phase_d   = '0;
          start_run = 1'b1;
        end
      end
      ST_ARM: begin
        if (cmd_stop) begin
          state_d = ST_DRAIN;
          phase_d = '0;
        end else if (phase_q == ARM_LAST) begin
          state_d = ST_RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (cmd_stop || timer_done) begin
          state_d = ST_DRAIN;
          phase_d = '0;
        end
      end
      ST_DRAIN: begin
        if (phase_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change in step with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      busy_q    <= 1'b0;
      operate_q <= 1'b0;
      rst_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      busy_q    <= (state_d != ST_IDLE);
      operate_q <= (state_d == ST_RUN);
      rst_cnt_q <= (state_d == ST_ARM);
    end
  end

  assign accept = io.tagger_rdy && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      record_q     <= '0;
    end else begin
      fifo_wr_q <= accept && !io.fifo_full;
      if (accept && !io.fifo_full) begin
        fifo_wdata_q <= io.tagger_data;
        record_q     <= record_q + ACQ_CNT_W'(1);
      end else if (start_run) begin
        record_q <= '0;
      end
    end
  end

`ifdef ACQ_SEQ_LOST_CNT_EN
  logic [15:0] lost_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lost_q <= '0;
    end else if (start_run) begin
      lost_q <= '0;
    end else if (accept && io.fifo_full && (lost_q != 16'hFFFF)) begin
      lost_q <= lost_q + 16'd1;
    end
  end

  assign lost_count = lost_q;
`else
  assign lost_count = '0;
`endif

  assign io.fifo_wr     = fifo_wr_q;
  assign io.fifo_wdata  = fifo_wdata_q;
  assign operate        = operate_q;
  assign reset_counter  = rst_cnt_q;
  assign busy           = busy_q;
  assign state          = state_q;
  assign record_count   = record_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: run timing, stop handling, record forwarding and reset.
module tb_acq_sequencer;
  import acq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start;
  logic        cmd_stop;
  logic [31:0] duration;
  logic        operate;
  logic        reset_counter;
  logic        busy;
  logic [1:0]  state;
  logic [31:0] record_count;
  logic [15:0] lost_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ACQ_SEQ_LOST_CNT_EN
  localparam int LOST_EXP = 3;
`else
  localparam int LOST_EXP = 0;
`endif

  acq_sequencer_if #(.DATA_W(ACQ_DATA_W)) io ();

  acq_sequencer #(
    .DATA_W       (ACQ_DATA_W),
    .RESET_CYCLES (2),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .duration      (duration),
    .io            (io),
    .operate       (operate),
    .reset_counter (reset_counter),
    .busy          (busy),
    .state         (state),
    .record_count  (record_count),
    .lost_count    (lost_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_op(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (operate) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, seen, 1'b1);
  endtask

  // Counts reset_counter, operate and DRAIN cycles from now until IDLE.
  task automatic count_run(output int rc, output int op, output int dr);
    bit reached = 1'b0;
    rc = 0; op = 0; dr = 0;
    for (int i = 0; i < 200; i++) begin
      if (state == 2'd0) begin
        reached = 1'b1;
        break;
      end
      rc += int'(reset_counter);
      op += int'(operate);
      dr += int'(state == 2'd3);
      tick();
    end
    chk("run_reaches_idle", reached, 1'b1);
  endtask

  logic [46:0] rec_vals [5] = '{47'h0000_0000_0001, 47'h7FFF_FFFF_FFFF,
                                47'h2AAA_AAAA_AAAA, 47'h5555_5555_5555,
                                47'h1234_5678_9ABC};

  initial begin
    int rc, op, dr, ops;
    reset_n        = 1'b1;
    cmd_start      = 1'b0;
    cmd_stop       = 1'b0;
    duration       = '0;
    io.tagger_rdy  = 1'b0;
    io.tagger_data = '0;
    io.fifo_full   = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_state", state, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_operate", operate, 1'b0);
    chk("rst_reset_counter", reset_counter, 1'b0);
    chk("rst_fifo_wr", io.fifo_wr, 1'b0);
    chk("rst_fifo_wdata", io.fifo_wdata, '0);
    chk("rst_record_count", record_count, '0);
    chk("rst_lost_count", lost_count, '0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Records and stop commands in IDLE are ignored.
    io.tagger_rdy = 1'b1; io.tagger_data = 47'h5A5A;
    tick();
    io.tagger_rdy = 1'b0;
    chk("idle_rec_wr", io.fifo_wr, 1'b0);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("idle_stop_state", state, 2'd0);
    chk("idle_stop_busy", busy, 1'b0);
    chk("idle_rec_count", record_count, '0);

    // duration=10: 2 reset cycles, 10 operate cycles, 4 drain cycles.
    duration = 32'd10; cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("d10_state_arm", state, 2'd1);
    chk("d10_rc_high", reset_counter, 1'b1);
    chk("d10_op_low", operate, 1'b0);
    chk("d10_busy", busy, 1'b1);
    count_run(rc, op, dr);
    chk("d10_rc_cycles", rc, 2);
    chk("d10_op_cycles", op, 10);
    chk("d10_drain_cycles", dr, 4);
    chk("d10_idle_busy", busy, 1'b0);

    // Unbounded run stopped in RUN cycle 25.
    duration = 32'd0; cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    wait_op("d0_wait_op");
    ops = 0;
    for (int i = 1; i <= 25; i++) begin
      ops += int'(operate);
      if (i == 25) cmd_stop = 1'b1;
      tick();
    end
    cmd_stop = 1'b0;
    chk("stop_op_cycles", ops, 25);
    chk("stop_op_low", operate, 1'b0);
    chk("stop_state_drain", state, 2'd3);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("drain_start_ignored", state, 2'd3);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("drain_stop_ignored", state, 2'd3);
    count_run(rc, op, dr);
    chk("stop_drain_rest", dr, 2);
    tick();
    chk("after_drain_idle", state, 2'd0);

    // Record in ARM is dropped; five records in RUN are forwarded.
    duration = 32'd20; cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    io.tagger_rdy = 1'b1; io.tagger_data = 47'h7FFF_0000_1111;
    tick();
    io.tagger_rdy = 1'b0;
    chk("arm_rec_wr", io.fifo_wr, 1'b0);
    wait_op("rec5_wait_op");
    for (int k = 0; k < 5; k++) begin
      io.tagger_rdy = 1'b1; io.tagger_data = rec_vals[k];
      tick();
      io.tagger_rdy = 1'b0;
      chk("rec5_wr", io.fifo_wr, 1'b1);
      chk("rec5_wdata", io.fifo_wdata, rec_vals[k]);
      tick();
      chk("rec5_wr_gap", io.fifo_wr, 1'b0);
    end
    chk("rec5_count", record_count, 32'd5);
    count_run(rc, op, dr);
    chk("rec5_op_rest", op, 10);
    tick(); tick();
    chk("rec5_count_held", record_count, 32'd5);

    // Alternating fifo_full over six back-to-back records.
    duration = 32'd0; cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("full_count_cleared", record_count, '0);
    wait_op("full_wait_op");
    for (int i = 0; i < 6; i++) begin
      io.tagger_rdy = 1'b1; io.tagger_data = 47'(100 + i); io.fifo_full = (i % 2 == 1);
      tick();
      chk("full_wr", io.fifo_wr, (i % 2 == 0));
      if (i % 2 == 0) chk("full_wdata", io.fifo_wdata, 64'(100 + i));
    end
    io.tagger_rdy = 1'b0; io.fifo_full = 1'b0;
    tick();
    chk("full_wr_idle", io.fifo_wr, 1'b0);
    chk("full_rec_count", record_count, 32'd3);
    chk("full_lost_count", lost_count, 16'(LOST_EXP));

    // Records in DRAIN are written; one arriving in IDLE is discarded.
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("drain_state", state, 2'd3);
    tick();
    io.tagger_rdy = 1'b1; io.tagger_data = 47'h0ABC;
    tick();
    io.tagger_rdy = 1'b0;
    chk("drain_a_wr", io.fifo_wr, 1'b1);
    chk("drain_a_data", io.fifo_wdata, 47'h0ABC);
    tick();
    io.tagger_rdy = 1'b1; io.tagger_data = 47'h0BBB;
    tick();
    chk("drain_b_idle", state, 2'd0);
    chk("drain_b_wr", io.fifo_wr, 1'b1);
    chk("drain_b_data", io.fifo_wdata, 47'h0BBB);
    io.tagger_data = 47'h0C0C;
    tick();
    io.tagger_rdy = 1'b0;
    chk("idle_c_wr", io.fifo_wr, 1'b0);
    chk("idle_c_count", record_count, 32'd5);
    chk("idle_c_lost", lost_count, 16'(LOST_EXP));

    // Stop during ARM ends reset_counter and goes to DRAIN.
    duration = 32'd0; cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("arm_stop_state", state, 2'd3);
    chk("arm_stop_rc", reset_counter, 1'b0);
    chk("arm_stop_op", operate, 1'b0);
    count_run(rc, op, dr);
    chk("arm_stop_drain", dr, 4);
    chk("arm_stop_count", record_count, '0);

    // Reset in RUN cycle 7 with a write pending.
    duration = 32'd0; cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    wait_op("rst_wait_op");
    repeat (5) tick();
    io.tagger_rdy = 1'b1; io.tagger_data = 47'h3C3C_3C3C;
    tick();
    io.tagger_rdy = 1'b0;
    chk("pre_rst_wr", io.fifo_wr, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_state", state, 2'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_operate", operate, 1'b0);
    chk("midrst_rc", reset_counter, 1'b0);
    chk("midrst_wr", io.fifo_wr, 1'b0);
    chk("midrst_wdata", io.fifo_wdata, '0);
    chk("midrst_count", record_count, '0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", state, 2'd0);

    // Start and stop together in IDLE: start wins.
    duration = 32'd3; cmd_start = 1'b1; cmd_stop = 1'b1; tick();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    chk("both_state_arm", state, 2'd1);
    count_run(rc, op, dr);
    chk("clean_rc_cycles", rc, 2);
    chk("clean_op_cycles", op, 3);
    chk("clean_drain_cycles", dr, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
